// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator
//   Initiator side of the register-space rreq/rack/wreq bus. The block takes one host
//   command at a time and turns it into a single bus read or write toward a register
//   bank. It then returns the read data, or a write completion, on a response channel.
//
//   Error handling:
//   - An access that the bank never acknowledges ends with an error response when the
//     timeout expires.
//   - A misaligned address ends with an error response and makes no bus access.
//   - Error responses are counted in a saturating debug counter.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_vld/cmd_rdy                host command handshake (cmd_rdy high only in IDLE)
//   cmd_wr/cmd_addr/cmd_wdata      command kind, byte address, write data
//   rsp_vld/rsp_rdy                response handshake
//   rsp_wr/rsp_rdata/rsp_err       response kind, read data, error flag
//   err_cnt                        saturating count of accepted error responses
//   rreq_addr/rreq_vld/rreq_rdy    read request channel
//   rack_data/rack_vld/rack_rdy    read acknowledge channel (rack_rdy = state is RD)
//   wreq_addr/wreq_data/wreq_vld/wreq_rdy  write request channel
module reg_bus_initiator #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic                rsp_wr,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]   rreq_addr,
  output logic                rreq_vld,
  input  logic                rreq_rdy,
  input  logic [DATA_W-1:0]   rack_data,
  input  logic                rack_vld,
  output logic                rack_rdy,
  output logic [ADDR_W-1:0]   wreq_addr,
  output logic [DATA_W-1:0]   wreq_data,
  output logic                wreq_vld,
  input  logic                wreq_rdy
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0]    TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [ERRCNT_W-1:0] ERR_ONE  = ERRCNT_W'(1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};
  localparam logic [DATA_W-1:0]   DATA_Z   = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0]   ADDR_Z   = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rd_hs;
  logic             wr_hs;

  // The bank's read-ready is only a mirror of rack_vld && rack_rdy.
  // The handshake is therefore taken directly from the rack signals.
  logic unused_rreq_rdy;
  assign unused_rreq_rdy = rreq_rdy;

  assign cmd_rdy = (state == IDLE);
  assign rack_rdy = (state == RD);
  assign rd_hs = rreq_vld && rack_vld && rack_rdy;
  assign wr_hs = wreq_vld && wreq_rdy;

  // Command/bus/response sequencer with registered outputs and timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= TMO_ZERO;
      rsp_vld   <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= DATA_Z;
      rsp_err   <= 1'b0;
      err_cnt   <= {ERRCNT_W{1'b0}};
      rreq_addr <= ADDR_Z;
      rreq_vld  <= 1'b0;
      wreq_addr <= ADDR_Z;
      wreq_data <= DATA_Z;
      wreq_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            rsp_wr <= cmd_wr;
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer straight away without touching the bus.
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= DATA_Z;
              state     <= RSP;
            end else if (cmd_wr) begin
              wreq_addr <= cmd_addr;
              wreq_data <= cmd_wdata;
              wreq_vld  <= 1'b1;
              tmo_cnt   <= TMO_ZERO;
              state     <= WR;
            end else begin
              rreq_addr <= cmd_addr;
              rreq_vld  <= 1'b1;
              tmo_cnt   <= TMO_ZERO;
              state     <= RD;
            end
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          // A handshake in the last allowed cycle still counts as success.
          if (wr_hs) begin
            wreq_vld  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= DATA_Z;
            state     <= RSP;
          end else if (tmo_cnt == TMO_LAST) begin
            wreq_vld  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= DATA_Z;
            state     <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        RD: begin
          if (rd_hs) begin
            rreq_vld  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rack_data;
            state     <= RSP;
          end else if (tmo_cnt == TMO_LAST) begin
            rreq_vld  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= DATA_Z;
            state     <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        RSP: begin
          // Response fields stay frozen until the host takes them.
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            if (rsp_err && (err_cnt != ERR_MAX)) begin
              err_cnt <= err_cnt + ERR_ONE;
            end else begin
              err_cnt <= err_cnt;
            end
            state <= IDLE;
          end else begin
            state <= RSP;
          end
        end
        default: begin
          rreq_vld <= 1'b0;
          wreq_vld <= 1'b0;
          rsp_vld  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
module tb_reg_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld, cmd_rdy, cmd_wr;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_vld, rsp_rdy, rsp_wr, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt;
  logic [15:0] rreq_addr;
  logic        rreq_vld, rreq_rdy;
  logic [31:0] rack_data;
  logic        rack_vld, rack_rdy;
  logic [15:0] wreq_addr;
  logic [31:0] wreq_data;
  logic        wreq_vld, wreq_rdy;

  int vecs = 0;
  int errs = 0;
  int n;

  reg_bus_initiator #(
    .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(16), .ERRCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .rreq_addr(rreq_addr), .rreq_vld(rreq_vld), .rreq_rdy(rreq_rdy),
    .rack_data(rack_data), .rack_vld(rack_vld), .rack_rdy(rack_rdy),
    .wreq_addr(wreq_addr), .wreq_data(wreq_data), .wreq_vld(wreq_vld),
    .wreq_rdy(wreq_rdy)
  );

  always #5 clk = ~clk;

  // Bank read-ready mirrors the rack handshake.
  assign rreq_rdy = rack_vld && rack_rdy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0; cmd_wdata = 32'h0;
    rsp_rdy = 1'b0; rack_data = 32'h0; rack_vld = 1'b0; wreq_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    // Reset state
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_wreq_vld", 32'(wreq_vld), 32'd0);
    chk("rst_rreq_vld", 32'(rreq_vld), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_rack_rdy", 32'(rack_rdy), 32'd0);
    chk("rst_wreq_addr", 32'(wreq_addr), 32'd0);

    // Write 0x20, zero-wait bank
    wreq_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'h0000_01C6;
    tick(); cmd_vld = 1'b0;
    chk("wr_vld_t1", 32'(wreq_vld), 32'd1);
    chk("wr_addr", 32'(wreq_addr), 32'h20);
    chk("wr_data", wreq_data, 32'h0000_01C6);
    chk("wr_no_rreq", 32'(rreq_vld), 32'd0);
    chk("wr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    tick();
    chk("wr_vld_t2", 32'(wreq_vld), 32'd0);
    chk("wr_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_wr", 32'(rsp_wr), 32'd1);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0; wreq_rdy = 1'b0;
    chk("wr_rsp_done", 32'(rsp_vld), 32'd0);
    chk("wr_idle", 32'(cmd_rdy), 32'd1);

    // Read 0x60, rack_vld already high while idle
    rack_vld = 1'b1; rack_data = 32'h5A5A_0000;
    chk("rd_rack_rdy_idle", 32'(rack_rdy), 32'd0);
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0060;
    tick(); cmd_vld = 1'b0;
    chk("rd_rreq_vld", 32'(rreq_vld), 32'd1);
    chk("rd_rack_rdy", 32'(rack_rdy), 32'd1);
    chk("rd_addr", 32'(rreq_addr), 32'h60);
    chk("rd_no_wreq", 32'(wreq_vld), 32'd0);
    tick();
    rack_vld = 1'b0;
    chk("rd_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("rd_rdata", rsp_rdata, 32'h5A5A_0000);
    chk("rd_err", 32'(rsp_err), 32'd0);
    chk("rd_rsp_wr", 32'(rsp_wr), 32'd0);
    chk("rd_rack_rdy_rsp", 32'(rack_rdy), 32'd0);
    chk("rd_rreq_drop", 32'(rreq_vld), 32'd0);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;

    // Read unmapped 0x40 -> timeout after 16 request cycles
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0040;
    tick(); cmd_vld = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && rreq_vld; i++) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'd0);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    chk("tmo_err_cnt", 32'(err_cnt), 32'd1);

    // Misaligned write 0x22: no bus activity, response next cycle
    wreq_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0022; cmd_wdata = 32'hDEAD_BEEF;
    tick(); cmd_vld = 1'b0;
    chk("mis_wreq_vld", 32'(wreq_vld), 32'd0);
    chk("mis_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("mis_err", 32'(rsp_err), 32'd1);
    chk("mis_rsp_wr", 32'(rsp_wr), 32'd1);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0; wreq_rdy = 1'b0;
    chk("mis_wreq_after", 32'(wreq_vld), 32'd0);
    chk("mis_err_cnt", 32'(err_cnt), 32'd2);

    // wreq_rdy rises in the 16th wait cycle -> success
    cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0024; cmd_wdata = 32'h0000_0011;
    tick(); cmd_vld = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("late_wreq_vld", 32'(wreq_vld), 32'd1);
    chk("late_no_rsp", 32'(rsp_vld), 32'd0);
    wreq_rdy = 1'b1;
    tick(); wreq_rdy = 1'b0;
    chk("late_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("late_err", 32'(rsp_err), 32'd0);
    chk("late_wreq_drop", 32'(wreq_vld), 32'd0);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    chk("late_err_cnt", 32'(err_cnt), 32'd2);

    // Response held while rsp_rdy low for 5 cycles
    rack_vld = 1'b1; rack_data = 32'h1234_5678;
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0064;
    tick();
    tick();
    rack_vld = 1'b0; rack_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h1234_5678);
      chk("hold_cmd_rdy", 32'(cmd_rdy), 32'd0);
      tick();
    end
    cmd_vld = 1'b0;
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    chk("hold_released", 32'(rsp_vld), 32'd0);

    // Reset mid-read
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0044;
    tick(); cmd_vld = 1'b0;
    tick(); tick();
    chk("mid_rreq_vld", 32'(rreq_vld), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rreq_drop", 32'(rreq_vld), 32'd0);
    chk("mid_wreq", 32'(wreq_vld), 32'd0);
    chk("mid_rsp", 32'(rsp_vld), 32'd0);
    chk("mid_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_vld) n++;
      tick();
    end
    chk("mid_no_rsp", 32'(n), 32'd0);

    // Saturating error counter
    rsp_rdy = 1'b1;
    cmd_wr = 1'b0; cmd_addr = 16'h0001;
    for (int i = 0; i < 254; i++) begin
      cmd_vld = 1'b1; tick(); cmd_vld = 1'b0; tick();
    end
    chk("sat_254", 32'(err_cnt), 32'd254);
    cmd_vld = 1'b1; tick(); cmd_vld = 1'b0; tick();
    chk("sat_255", 32'(err_cnt), 32'd255);
    cmd_vld = 1'b1; tick(); cmd_vld = 1'b0; tick();
    chk("sat_256", 32'(err_cnt), 32'hFF);
    rsp_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
